// File: rtl/rrp_mult_sched.sv
// rrp_mult_sched: round-robin scheduler in front of one shared, fully pipelined
// rRp_mult instance. Each clock it may accept one request, register that
// requester's operands into the multiplier, and carry a tag alongside the
// multiplier latency. The tag steers the product back to whoever asked for it.
//
// Ports
//   clock_i      system clock
//   reset_i      synchronous, active-high reset
//   enable_i     1 = grants allowed, 0 = no new grants (pipeline still drains)
//   req_i        per-requester request, held with operands until granted
//   req_x_i      packed x operands, requester i at [i*OW +: OW]
//   req_y_i      packed y operands, same packing
//   gnt_o        one-hot grant, combinational, same cycle as the accepted request
//   mult_x_o     registered x operand to the multiplier
//   mult_y_o     registered y operand to the multiplier
//   mult_p_i     multiplier product
//   rsp_valid_o  registered one-hot owner of rsp_p_o
//   rsp_p_o      registered product
//   inflight_o   grants issued whose response has not been emitted yet
//   idle_o       nothing in flight and no grant this cycle
module rrp_mult_sched #(
    parameter int WIDTH   = 7,
    parameter int RADIX   = 2,
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    localparam int D  = $clog2(RADIX) + 1,
    localparam int OW = D * WIDTH,
    localparam int PW = D * (2 * WIDTH + 1),
    localparam int IW = $clog2(NREQ),
    localparam int CW = $clog2(LATENCY + 3)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*OW-1:0] req_x_i,
    input  logic [NREQ*OW-1:0] req_y_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [OW-1:0]      mult_x_o,
    output logic [OW-1:0]      mult_y_o,
    input  logic [PW-1:0]      mult_p_i,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [PW-1:0]      rsp_p_o,
    output logic [CW-1:0]      inflight_o,
    output logic               idle_o
);

    // Unpack operand buses into per-requester arrays.
    logic [OW-1:0] x_arr [NREQ];
    logic [OW-1:0] y_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x_i[gi*OW +: OW];
            assign y_arr[gi] = req_y_i[gi*OW +: OW];
        end
    endgenerate

    // Tag pipe: stage 0 is written together with mult_x/mult_y, the last
    // stage lines up with a valid product on mult_p_i.
    localparam int NSTG = LATENCY + 1;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   mult_x_q, mult_x_d;
    logic [OW-1:0]   mult_y_q, mult_y_d;
    logic            tag_vld_q [NSTG];
    logic [IW-1:0]   tag_idx_q [NSTG];
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]   rsp_p_q, rsp_p_d;
    logic [CW-1:0]   inflight_q, inflight_d;

    logic [NREQ-1:0] gnt_vec;
    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;

    // Round-robin search starting one past the last granted index.
    always_comb begin
        gnt_vec = '0;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        if (enable_i) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IW'((int'(ptr_q) + k) % NREQ);
                if (!gnt_any && req_i[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = gnt_any ? gnt_idx : ptr_q;
        mult_x_d    = gnt_any ? x_arr[gnt_idx] : '0;
        mult_y_d    = gnt_any ? y_arr[gnt_idx] : '0;
        rsp_valid_d = '0;
        rsp_p_d     = rsp_p_q;
        if (tag_vld_q[NSTG-1]) begin
            rsp_valid_d[tag_idx_q[NSTG-1]] = 1'b1;
            rsp_p_d                        = mult_p_i;
        end
        // A grant and a response in the same cycle cancel out.
        inflight_d = inflight_q;
        case ({gnt_any, |rsp_valid_q})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q       <= IW'(NREQ - 1);
            mult_x_q    <= '0;
            mult_y_q    <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            inflight_q  <= '0;
            for (int s = 0; s < NSTG; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_idx_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            mult_x_q     <= mult_x_d;
            mult_y_q     <= mult_y_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_p_q      <= rsp_p_d;
            inflight_q   <= inflight_d;
            tag_vld_q[0] <= gnt_any;
            tag_idx_q[0] <= gnt_any ? gnt_idx : '0;
            // The multiplier cannot stall, so the tags never stall either.
            for (int s = 1; s < NSTG; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign gnt_o       = gnt_vec;
    assign mult_x_o    = mult_x_q;
    assign mult_y_o    = mult_y_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_p_o     = rsp_p_q;
    assign inflight_o  = inflight_q;
    assign idle_o      = (inflight_q == '0) && !gnt_any;

endmodule

// File: tb/tb_rrp_mult_sched.sv
// Directed bench for rrp_mult_sched. A two-register behavioural multiplier
// stands in for rRp_mult (product = x * y on the raw operand bits); the
// scheduler only routes data, so any deterministic two-stage function will do.
// Expected responses are queued when a grant is checked and compared by a
// negedge monitor for owner, product and cycle.
module tb_rrp_mult_sched;
    localparam int NREQ = 4;
    localparam int OW   = 14;
    localparam int PW   = 30;
    localparam int CW   = 3;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [NREQ-1:0]   req;
    logic [NREQ*OW-1:0] req_x;
    logic [NREQ*OW-1:0] req_y;
    logic [NREQ-1:0]   gnt;
    logic [OW-1:0]     mult_x;
    logic [OW-1:0]     mult_y;
    logic [PW-1:0]     mult_p;
    logic [NREQ-1:0]   rsp_valid;
    logic [PW-1:0]     rsp_p;
    logic [CW-1:0]     inflight;
    logic              idle;

    rrp_mult_sched dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .req_i       (req),
        .req_x_i     (req_x),
        .req_y_i     (req_y),
        .gnt_o       (gnt),
        .mult_x_o    (mult_x),
        .mult_y_o    (mult_y),
        .mult_p_i    (mult_p),
        .rsp_valid_o (rsp_valid),
        .rsp_p_o     (rsp_p),
        .inflight_o  (inflight),
        .idle_o      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in multiplier: input register then output register.
    logic [OW-1:0] mx_r, my_r;
    always @(posedge clk) begin
        mx_r   <= mult_x;
        my_r   <= mult_y;
        mult_p <= PW'(mx_r) * PW'(my_r);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [PW-1:0]   p;
        int              cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [OW-1:0] xv [NREQ];
    logic [OW-1:0] yv [NREQ];

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [PW-1:0] prod(input int i);
        return PW'(xv[i]) * PW'(yv[i]);
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*OW +: OW] = xv[i];
            req_y[i*OW +: OW] = yv[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests, check the combinational grant, queue the
    // expected response and advance to just after the next edge.
    task automatic step(input logic [NREQ-1:0] r, input logic en,
                        input logic [NREQ-1:0] eg, input string tag);
        exp_t e;
        req    = r;
        enable = en;
        #1;
        chk(32'(gnt), 32'(eg), tag);
        $display("grant %s req=%b en=%b gnt=%b cyc=%0d", tag, r, en, gnt, cyc);
        if (eg != '0) begin
            e.oh  = eg;
            e.p   = prod(oh2i(eg));
            e.cyc = cyc + 4;
            exp_q.push_back(e);
        end
        tick();
    endtask

    // Response monitor.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rsp_valid !== '0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected observed %b expected none", rsp_valid);
                end
            end else begin
                mon_e = exp_q.pop_front();
                chk(32'(rsp_valid), 32'(mon_e.oh), "rsp_valid");
                chk(32'(rsp_p), 32'(mon_e.p), "rsp_p");
                chk(32'(cyc), 32'(mon_e.cyc), "rsp_cycle");
                $display("rsp cyc=%0d valid=%b p=%h", cyc, rsp_valid, rsp_p);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        req    = '0;
        for (int i = 0; i < NREQ; i++) begin
            xv[i] = '0;
            yv[i] = '0;
        end
        pack_ops();

        // 1: reset state
        tick(); tick(); tick();
        chk(32'(gnt), 32'(0), "rst_gnt");
        chk(32'(rsp_valid), 32'(0), "rst_rsp_valid");
        chk(32'(mult_x), 32'(0), "rst_mult_x");
        chk(32'(inflight), 32'(0), "rst_inflight");
        chk(32'(idle), 32'(1), "rst_idle");
        reset  = 1'b0;
        req    = 4'b1111;
        enable = 1'b1;
        #1;
        chk(32'(gnt), 32'(4'b0001), "rst_priority");
        req = '0;
        #1;

        // 2: single request
        xv[0] = OW'($urandom);
        yv[0] = OW'($urandom);
        pack_ops();
        step(4'b0001, 1'b1, 4'b0001, "t2_gnt");
        req = '0;
        chk(32'(mult_x), 32'(xv[0]), "t2_mult_x");
        chk(32'(mult_y), 32'(yv[0]), "t2_mult_y");
        chk(32'(inflight), 32'(1), "t2_inflight");
        tick(); tick(); tick();
        chk(32'(rsp_valid), 32'(4'b0001), "t2_rsp_valid");
        chk(32'(rsp_p), 32'(prod(0)), "t2_rsp_p");
        tick();
        chk(32'(idle), 32'(1), "t2_idle");
        chk(32'(inflight), 32'(0), "t2_inflight_end");

        // 3: all requesting; a grant to 3 first puts requester 0 next in line
        xv[0] = 14'h1abc; yv[0] = 14'h0d21;
        xv[1] = 14'h0f0f; yv[1] = 14'h3003;
        xv[2] = 14'h3fff; yv[2] = 14'h3fff;
        xv[3] = 14'h0001; yv[3] = 14'h2a5a;
        pack_ops();
        step(4'b1000, 1'b1, 4'b1000, "t3_pre");
        for (int k = 0; k < 12; k++) begin
            chk(32'(inflight), 32'((k + 1 < 4) ? k + 1 : 4), $sformatf("t3_inflight%0d", k));
            step(4'b1111, 1'b1, 4'(1 << (k % 4)), $sformatf("t3_gnt%0d", k));
        end
        req = '0;
        tick(); tick(); tick(); tick();
        chk(32'(inflight), 32'(0), "t3_inflight_end");
        chk(32'(idle), 32'(1), "t3_idle");

        // 4: wrap-around
        step(4'b0010, 1'b1, 4'b0010, "t4_gnt1");
        step(4'b1010, 1'b1, 4'b1000, "t4_gnt3");
        step(4'b1010, 1'b1, 4'b0010, "t4_wrap");
        req = 4'b1111;
        #1;
        chk(32'(gnt), 32'(4'b0100), "t4_ptr_at_1");
        req = '0;
        #1;
        tick(); tick(); tick(); tick();
        chk(32'(inflight), 32'(0), "t4_inflight_end");

        // 5: disable after three grants, pipeline drains
        step(4'b1111, 1'b1, 4'b0100, "t5_gnt0");
        step(4'b1111, 1'b1, 4'b1000, "t5_gnt1");
        step(4'b1111, 1'b1, 4'b0001, "t5_gnt2");
        for (int j = 3; j <= 7; j++) begin
            chk(32'(inflight), 32'((j <= 4) ? 3 : 7 - j), $sformatf("t5_inflight%0d", j));
            chk(32'(idle), 32'(j == 7), $sformatf("t5_idle%0d", j));
            step(4'b1111, 1'b0, 4'b0000, $sformatf("t5_off%0d", j));
        end

        // 6: reset with three operations in flight
        step(4'b1111, 1'b1, 4'b0010, "t6_gnt0");
        step(4'b1111, 1'b1, 4'b0100, "t6_gnt1");
        step(4'b1111, 1'b1, 4'b1000, "t6_gnt2");
        req   = '0;
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk(32'(rsp_valid), 32'(0), $sformatf("t6_rsp%0d", j));
            chk(32'(inflight), 32'(0), $sformatf("t6_inflight%0d", j));
            chk(32'(mult_x), 32'(0), $sformatf("t6_mult_x%0d", j));
            tick();
        end
        req = 4'b1111;
        #1;
        chk(32'(gnt), 32'(4'b0001), "t6_ptr_reset");
        req = '0;
        #1;
        chk(32'(exp_q.size()), 32'(0), "all_rsp_seen");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
